// File: rtl/pipe_adder_hs.sv
// Pipelined WIDTH-bit adder/subtractor: one CW-bit chunk per stage, carry rippled
// through stage registers, valid/ready handshake with whole-pipe stall.

module pipe_adder_hs_stage #(
  parameter int WIDTH = 8,
  parameter int CW    = 4,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] s_i,
  input  logic             c_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [WIDTH-1:0] s_o,
  output logic             c_o,
  output logic             ovf_o
);
  localparam int LO = IDX * CW;

  logic [CW:0]      sum;
  logic [WIDTH-1:0] s_d;
  logic             ovf_d;

  logic             vld_q;
  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic             c_q, ovf_q;

  assign sum = {1'b0, a_i[LO +: CW]} + {1'b0, b_i[LO +: CW]} + {{CW{1'b0}}, c_i};

  // Only the last stage's ovf is consumed; there the MSB of s_d is final.
  always_comb begin
    s_d          = s_i;
    s_d[LO +: CW] = sum[CW-1:0];
    ovf_d        = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (s_d[WIDTH-1] != a_i[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      c_q   <= 1'b0;
      ovf_q <= 1'b0;
    end else if (en_i) begin
      vld_q <= vld_i;
      // Bubbles leave the data untouched so results stay stable and never X.
      if (vld_i) begin
        a_q   <= a_i;
        b_q   <= b_i;
        s_q   <= s_d;
        c_q   <= sum[CW];
        ovf_q <= ovf_d;
      end
    end
  end

  assign vld_o = vld_q;
  assign a_o   = a_q;
  assign b_o   = b_q;
  assign s_o   = s_q;
  assign c_o   = c_q;
  assign ovf_o = ovf_q;

  logic unused_ok;
  assign unused_ok = ^s_i[LO +: CW];
endmodule

module pipe_adder_hs #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cy,
  output logic             ovf
);
  localparam int CW = WIDTH / STAGES;

  generate
    if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
      $error("pipe_adder_hs: WIDTH must be >= 1 and divisible by STAGES");
    end
  endgenerate

  // Index 0 is the conditioned input; index k is the register of stage k.
  logic [STAGES:0]            vld_pipe;
  logic [STAGES:0]            c_pipe;
  logic [STAGES:0][WIDTH-1:0] a_pipe, b_pipe, s_pipe;
  logic [STAGES:1]            ovf_pipe;
  logic                       stall;

  assign stall = vld_pipe[STAGES] && !out_ready;

  // Subtract as a + ~b + ~c: borrow-in inverts into carry-in, cy reads as NOT borrow.
  assign vld_pipe[0] = in_valid;
  assign a_pipe[0]   = a;
  assign b_pipe[0]   = sub ? ~b : b;
  assign c_pipe[0]   = sub ? ~c : c;
  assign s_pipe[0]   = '0;

  genvar k;
  generate
    for (k = 1; k <= STAGES; k++) begin : g_stage
      pipe_adder_hs_stage #(
        .WIDTH (WIDTH),
        .CW    (CW),
        .IDX   (k - 1)
      ) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (!stall),
        .vld_i (vld_pipe[k-1]),
        .a_i   (a_pipe[k-1]),
        .b_i   (b_pipe[k-1]),
        .s_i   (s_pipe[k-1]),
        .c_i   (c_pipe[k-1]),
        .vld_o (vld_pipe[k]),
        .a_o   (a_pipe[k]),
        .b_o   (b_pipe[k]),
        .s_o   (s_pipe[k]),
        .c_o   (c_pipe[k]),
        .ovf_o (ovf_pipe[k])
      );
    end
  endgenerate

  assign in_ready  = !stall;
  assign out_valid = vld_pipe[STAGES];
  assign s         = s_pipe[STAGES];
  assign cy        = c_pipe[STAGES];
  assign ovf       = ovf_pipe[STAGES];

  logic unused_ok;
  assign unused_ok = ^{a_pipe[STAGES], b_pipe[STAGES], ovf_pipe};
endmodule

// File: tb/tb_pipe_adder_hs.sv
// Directed bench: 8-bit/2-stage adder for function and handshake, 1-bit/1-stage for full-adder table.

module tb_pipe_adder_hs;
  logic       clk = 1'b0;
  logic       rst_n;

  logic       in_valid, in_ready, c, sub, out_valid, out_ready, cy, ovf;
  logic [7:0] a, b, s;

  logic       in_valid1, in_ready1, c1, sub1, out_valid1, out_ready1, cy1, ovf1;
  logic [0:0] a1, b1, s1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_adder_hs #(.WIDTH(8), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cy(cy), .ovf(ovf)
  );

  pipe_adder_hs #(.WIDTH(1), .STAGES(1)) dut_fa (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .c(c1), .sub(sub1), .out_valid(out_valid1), .out_ready(out_ready1),
    .s(s1), .cy(cy1), .ovf(ovf1)
  );

  task automatic test_reset();
    n_checks++;
    if ({out_valid, s, cy, ovf, in_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b s=%h cy=%b ovf=%b rdy=%b, want v=0 s=00 cy=0 ovf=0 rdy=1",
               out_valid, s, cy, ovf, in_ready);
    end
    n_checks++;
    if ({out_valid1, s1, cy1, ovf1, in_ready1} !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_state_fa: got %b, want 00001", {out_valid1, s1, cy1, ovf1, in_ready1});
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_wrap();
    a = 8'hFF; b = 8'h01; c = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_early: out_valid=%b after 1 edge, want 0", out_valid);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, s, cy, ovf} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL wrap_result: got v=%b s=%h cy=%b ovf=%b, want v=1 s=00 cy=1 ovf=0",
               out_valid, s, cy, ovf);
    end
  endtask

  task automatic test_overflow();
    a = 8'h7F; b = 8'h01; c = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 8'h80; b = 8'h01; c = 1'b0; sub = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; sub = 1'b0;
    n_checks++;
    if ({out_valid, s, cy, ovf} !== {1'b1, 8'h80, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_add: got v=%b s=%h cy=%b ovf=%b, want v=1 s=80 cy=0 ovf=1",
               out_valid, s, cy, ovf);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, s, cy, ovf} !== {1'b1, 8'h7F, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_sub: got v=%b s=%h cy=%b ovf=%b, want v=1 s=7f cy=1 ovf=1",
               out_valid, s, cy, ovf);
    end
  endtask

  task automatic test_borrow();
    a = 8'h05; b = 8'h07; c = 1'b0; sub = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    c = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; sub = 1'b0; c = 1'b0;
    n_checks++;
    if ({out_valid, s, cy, ovf} !== {1'b1, 8'hFE, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL borrow_c0: got v=%b s=%h cy=%b ovf=%b, want v=1 s=fe cy=0 ovf=0",
               out_valid, s, cy, ovf);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, s, cy, ovf} !== {1'b1, 8'hFD, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL borrow_c1: got v=%b s=%h cy=%b ovf=%b, want v=1 s=fd cy=0 ovf=0",
               out_valid, s, cy, ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_pressure();
    int sent = 0;
    int got = 0;
    int stall_left = 0;
    bit stalled_once = 1'b0;
    bit acc, del;
    logic [7:0] exp;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      in_valid = (sent < 4);
      a = 8'(sent + 1); b = 8'(sent + 1); c = 1'b0; sub = 1'b0;
      if (out_valid && !stalled_once) begin
        stalled_once = 1'b1;
        stall_left = 3;
      end
      out_ready = (stall_left == 0);
      #1;
      if (stall_left > 0) begin
        n_checks++;
        if ({in_ready, out_valid, s} !== {1'b0, 1'b1, 8'h02}) begin
          n_fail++;
          $display("FAIL bp_hold: cyc %0d got rdy=%b v=%b s=%h, want rdy=0 v=1 s=02",
                   cyc, in_ready, out_valid, s);
        end
        stall_left--;
      end
      acc = in_valid && in_ready;
      del = out_valid && out_ready;
      if (del) begin
        exp = 8'((got + 1) * 2);
        n_checks++;
        if (s !== exp) begin
          n_fail++;
          $display("FAIL bp_order: result %0d got s=%h, want %h", got, s, exp);
        end
        got++;
      end
      if (acc) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++;
    if (got != 4) begin
      n_fail++;
      $display("FAIL bp_count: got %0d results within budget, want 4", got);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_no_dup: out_valid=%b after 4 results, want 0", out_valid);
    end
  endtask

  task automatic test_reset_midflight();
    bit seen = 1'b0;
    a = 8'h11; b = 8'h22; c = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 8'h33; b = 8'h44;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, s} !== {1'b1, 8'h33}) begin
      n_fail++;
      $display("FAIL rst_pre: got v=%b s=%h, want v=1 s=33", out_valid, s);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, s, cy, ovf, in_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_async: got v=%b s=%h cy=%b ovf=%b rdy=%b, want v=0 s=00 cy=0 ovf=0 rdy=1",
               out_valid, s, cy, ovf, in_ready);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL rst_discard: out_valid=1 seen after reset release, want 0");
    end
    a = 8'h10; b = 8'h20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, s, cy} !== {1'b1, 8'h30, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_after: got v=%b s=%h cy=%b, want v=1 s=30 cy=0", out_valid, s, cy);
    end
  endtask

  task automatic test_full_adder();
    logic [1:0] fa_exp [8];
    fa_exp = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
    sub1 = 1'b0; out_ready1 = 1'b1; in_valid1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      {a1, b1, c1} = 3'(i);
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid1, cy1, s1} !== {1'b1, fa_exp[i]}) begin
        n_fail++;
        $display("FAIL fa_table: abc=%0d got v=%b cy=%b s=%b, want v=1 {cy,s}=%b",
                 i, out_valid1, cy1, s1, fa_exp[i]);
      end
    end
    in_valid1 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; c = 1'b0; sub = 1'b0; out_ready = 1'b1;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0; sub1 = 1'b0; out_ready1 = 1'b1;
    #12;
    test_reset();
    test_add_wrap();
    test_overflow();
    test_borrow();
    test_back_pressure();
    test_reset_midflight();
    test_full_adder();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_adder_hs.md
Name: pipe_adder_hs

Overview:
- Parametrised, pipelined WIDTH-bit adder/subtractor; sequential successor to the single-bit full adder (a, b, c -> s, cy).
- Splits the operand into STAGES equal chunks. Each stage adds one chunk and passes the carry to the next stage.
- Valid/ready handshake on input and output, with whole-pipeline stall under back-pressure.
- Sits between operand producers and result consumers in the datapath; adds subtract mode and a signed-overflow flag.

Parameters:
- WIDTH, 8, operand/sum width in bits; must be >= 1.
- STAGES, 2, pipeline depth and chunk count; WIDTH % STAGES == 0 is required (elaboration error otherwise).
- CW, WIDTH/STAGES (derived, localparam), chunk width handled per stage.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- c  input  1  carry-in (add) / borrow-in (sub)
- sub  input  1  0 = a+b+c, 1 = a-b-c
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- s  output  WIDTH  sum/difference
- cy  output  1  carry-out (add); NOT borrow-out (sub: 1 = no borrow)
- ovf  output  1  two's-complement signed overflow

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values while rst_n = 0 and after release: all stage valid bits = 0, out_valid = 0, s = 0, cy = 0, ovf = 0, in_ready = 1.
- Reset mid-operation: in-flight beats are discarded immediately, with no partial output. The first accept after release behaves as from empty.
- Operand conditioning at entry:
  - b_eff = sub ? ~b : b
  - cin_eff = sub ? ~c : c
  - Result = a + b_eff + cin_eff, modulo 2^WIDTH. The carry out of the MSB is cy.
- Stage k (1..STAGES) computes bits [k*CW-1:(k-1)*CW] from the chunk of a and b_eff plus the carry registered by stage k-1. Stage 1 uses cin_eff.
- Upper operand chunks and lower result chunks are carried along in pipeline registers (operand skew).
- ovf = (a[MSB] == b_eff[MSB]) && (s[MSB] != a[MSB]). It is computed in the last stage from the registered MSBs.
- Handshake:
  - Transfer in: in_valid && in_ready.
  - Transfer out: out_valid && out_ready.
  - stall = out_valid && !out_ready.
  - in_ready = !stall.
  - When stall = 1, every stage register holds (data and valid). A beat presented while in_ready = 0 is not captured.
- Latency: a beat accepted on edge N appears with out_valid = 1 after edge N+STAGES-1, i.e. STAGES registered stages, with no stall. Throughput is 1 beat/cycle.
- Bubbles propagate and are not collapsed during a stall.
- s, cy and ovf are held stable while out_valid && !out_ready. Their values are don't-care when out_valid = 0, but they are never X after reset.
- Ordering: strictly FIFO. No beat is dropped or duplicated.
- in_valid with sub or c changing between beats: each beat uses its own captured sub/c.
- STAGES = 1: a single registered stage with latency 1. WIDTH = 1, STAGES = 1 reproduces the full-adder truth table, registered.

Test Plan:
- Add with carry wrap (WIDTH=8, STAGES=2): a=0xFF, b=0x01, c=0, sub=0, out_ready=1 -> 2 cycles later s=0x00, cy=1, ovf=0.
- Signed overflow: a=0x7F, b=0x01, c=0 -> s=0x80, cy=0, ovf=1. Then sub=1, a=0x80, b=0x01, c=0 -> s=0x7F, cy=1, ovf=1.
- Borrow: sub=1, a=0x05, b=0x07, c=0 -> s=0xFE, cy=0 (borrow), ovf=0. Same with c=1 -> s=0xFD.
- Back-pressure: 4 back-to-back beats (1+1, 2+2, 3+3, 4+4), out_ready=0 for 3 cycles once the first result is valid:
  - in_ready drops, s holds 0x02.
  - After release, results emerge as 0x02, 0x04, 0x06, 0x08 in order, with no loss or duplication.
- Reset mid-flight: two beats accepted, then rst_n=0 for 1 cycle between edges -> out_valid=0 and s=0 immediately (asynchronous). No result for those beats appears after release; the next beat 0x10+0x20 gives 0x30.
- Compatibility (WIDTH=1, STAGES=1): all 8 {a,b,c} combos with sub=0 -> {cy,s} equals the full-adder truth table (e.g. 1,0,1 -> s=0, cy=1), each 1 cycle after accept.
